// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// Arbitrates I-cache refills, D-cache refills and D-cache writes onto a single memory port.
// Optional watchdog on busy states is enabled by defining MEM_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no transaction; write wins, reads alternate round-robin
// RD_IC | I-cache refill outstanding on the memory read channel
// RD_DC | D-cache refill outstanding on the memory read channel
// WR_DC | D-cache write outstanding on the memory write channel
// RESP  | one-cycle done pulse to the granted requester
module mem_arbiter #(
  parameter int ADDR_WIDTH       = 64,
  parameter int DATA_WIDTH       = 64,
  parameter int CACHE_LINE_WIDTH = 256,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_ic_rd_req,
  input  logic [ADDR_WIDTH-1:0]       i_ic_rd_addr,
  output logic                        o_ic_rd_done,
  input  logic                        i_dc_rd_req,
  input  logic [ADDR_WIDTH-1:0]       i_dc_rd_addr,
  output logic                        o_dc_rd_done,
  output logic [CACHE_LINE_WIDTH-1:0] o_line,
  input  logic                        i_dc_wr_req,
  input  logic [ADDR_WIDTH-1:0]       i_dc_wr_addr,
  input  logic [DATA_WIDTH-1:0]       i_dc_wr_data,
  input  logic [7:0]                  i_dc_wr_strobe,
  output logic                        o_dc_wr_done,
  output logic                        o_mem_read_req,
  output logic [ADDR_WIDTH-1:0]       o_mem_read_address,
  input  logic                        i_mem_read_done,
  input  logic [CACHE_LINE_WIDTH-1:0] i_cache_line,
  output logic                        o_mem_write_valid,
  output logic [ADDR_WIDTH-1:0]       o_mem_write_address,
  output logic [DATA_WIDTH-1:0]       o_mem_write_data,
  output logic [7:0]                  o_write_strobe,
  input  logic                        i_mem_write_done,
  output logic                        o_timeout_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_IC = 3'd1,
    RD_DC = 3'd2,
    WR_DC = 3'd3,
    RESP  = 3'd4
  } state_e;

  state_e                      state_q, state_d;
  logic                        rr_dc_q, rr_dc_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
  logic [7:0]                  wstrb_q, wstrb_d;
  logic [CACHE_LINE_WIDTH-1:0] line_q, line_d;
  logic                        ic_done_q, ic_done_d;
  logic                        dc_done_q, dc_done_d;
  logic                        wr_done_q, wr_done_d;
  logic                        timeout_hit;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic             err_q, err_d;
  logic             busy;
  logic             rsp_done;

  assign busy        = (state_q == RD_IC) || (state_q == RD_DC) || (state_q == WR_DC);
  assign rsp_done    = (state_q == WR_DC) ? i_mem_write_done : i_mem_read_done;
  assign timeout_hit = busy && (tcnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Held at zero in IDLE so every grant starts counting from 0.
  always_comb begin
    tcnt_d = tcnt_q;
    err_d  = err_q | (timeout_hit & ~rsp_done);
    if (state_q == IDLE) begin
      tcnt_d = '0;
    end else if (busy) begin
      tcnt_d = tcnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      err_q  <= err_d;
    end
  end

  assign o_timeout_err = err_q;
`else
  assign timeout_hit   = 1'b0;
  assign o_timeout_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rr_dc_d   = rr_dc_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    line_d    = line_q;
    ic_done_d = 1'b0;
    dc_done_d = 1'b0;
    wr_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_dc_wr_req) begin
          state_d = WR_DC;
          addr_d  = i_dc_wr_addr;
          wdata_d = i_dc_wr_data;
          wstrb_d = i_dc_wr_strobe;
        end else if (i_ic_rd_req && (!i_dc_rd_req || !rr_dc_q)) begin
          state_d = RD_IC;
          addr_d  = i_ic_rd_addr;
          rr_dc_d = 1'b1;
        end else if (i_dc_rd_req) begin
          state_d = RD_DC;
          addr_d  = i_dc_rd_addr;
          rr_dc_d = 1'b0;
        end
      end
      RD_IC: begin
        if (i_mem_read_done || timeout_hit) begin
          state_d   = RESP;
          ic_done_d = 1'b1;
          if (i_mem_read_done) line_d = i_cache_line;
        end
      end
      RD_DC: begin
        if (i_mem_read_done || timeout_hit) begin
          state_d   = RESP;
          dc_done_d = 1'b1;
          if (i_mem_read_done) line_d = i_cache_line;
        end
      end
      WR_DC: begin
        if (i_mem_write_done || timeout_hit) begin
          state_d   = RESP;
          wr_done_d = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      rr_dc_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      line_q    <= '0;
      ic_done_q <= 1'b0;
      dc_done_q <= 1'b0;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_dc_q   <= rr_dc_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      line_q    <= line_d;
      ic_done_q <= ic_done_d;
      dc_done_q <= dc_done_d;
      wr_done_q <= wr_done_d;
    end
  end

  // Both channels share one address register; only the active channel's valid qualifies it.
  assign o_mem_read_req      = (state_q == RD_IC) || (state_q == RD_DC);
  assign o_mem_read_address  = addr_q;
  assign o_mem_write_valid   = (state_q == WR_DC);
  assign o_mem_write_address = addr_q;
  assign o_mem_write_data    = wdata_q;
  assign o_write_strobe      = wstrb_q;
  assign o_line              = line_q;
  assign o_ic_rd_done        = ic_done_q;
  assign o_dc_rd_done        = dc_done_q;
  assign o_dc_wr_done        = wr_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Directed bench for mem_arbiter: transaction-level reference model checked every cycle,
// plus literal expectations for latency, grant order, reset and watchdog behaviour.
module tb_mem_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int LW = 256;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TO    = 8;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 255;
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ic_req = 1'b0, dc_req = 1'b0, wr_req = 1'b0;
  logic [AW-1:0] ic_addr = '0, dc_addr = '0, wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [7:0]    wr_strb = '0;
  logic mem_rd_done = 1'b0, mem_wr_done = 1'b0;
  logic [LW-1:0] cache_line = '0;
  logic o_ic_rd_done, o_dc_rd_done, o_dc_wr_done, o_mem_read_req, o_mem_write_valid, o_timeout_err;
  logic [LW-1:0] o_line;
  logic [AW-1:0] o_mem_read_address, o_mem_write_address;
  logic [DW-1:0] o_mem_write_data;
  logic [7:0]    o_write_strobe;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CACHE_LINE_WIDTH(LW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ic_rd_req(ic_req), .i_ic_rd_addr(ic_addr), .o_ic_rd_done(o_ic_rd_done),
    .i_dc_rd_req(dc_req), .i_dc_rd_addr(dc_addr), .o_dc_rd_done(o_dc_rd_done),
    .o_line(o_line),
    .i_dc_wr_req(wr_req), .i_dc_wr_addr(wr_addr), .i_dc_wr_data(wr_data),
    .i_dc_wr_strobe(wr_strb), .o_dc_wr_done(o_dc_wr_done),
    .o_mem_read_req(o_mem_read_req), .o_mem_read_address(o_mem_read_address),
    .i_mem_read_done(mem_rd_done), .i_cache_line(cache_line),
    .o_mem_write_valid(o_mem_write_valid), .o_mem_write_address(o_mem_write_address),
    .o_mem_write_data(o_mem_write_data), .o_write_strobe(o_write_strobe),
    .i_mem_write_done(mem_wr_done), .o_timeout_err(o_timeout_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string nm, logic [LW-1:0] act, logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: phase 0 waiting, 1 memory outstanding, 2 reporting; who 0=IC 1=DC 2=WR.
  int            m_phase = 0, m_who = 0, m_busy = 0;
  bit            m_ptr_dc = 1'b0, m_err = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [7:0]    m_strb = '0;
  logic [LW-1:0] m_line = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0; m_ptr_dc <= 1'b0; m_err <= 1'b0; m_busy <= 0;
      m_addr <= '0; m_data <= '0; m_strb <= '0; m_line <= '0;
    end else if (m_phase == 0) begin
      if (wr_req) begin
        m_phase <= 1; m_who <= 2; m_busy <= 0;
        m_addr <= wr_addr; m_data <= wr_data; m_strb <= wr_strb;
      end else if (ic_req && (!dc_req || !m_ptr_dc)) begin
        m_phase <= 1; m_who <= 0; m_busy <= 0; m_addr <= ic_addr; m_ptr_dc <= 1'b1;
      end else if (dc_req) begin
        m_phase <= 1; m_who <= 1; m_busy <= 0; m_addr <= dc_addr; m_ptr_dc <= 1'b0;
      end
    end else if (m_phase == 1) begin
      if ((m_who == 2) ? mem_wr_done : mem_rd_done) begin
        m_phase <= 2;
        if (m_who != 2) m_line <= cache_line;
      end else if (TO_EN && m_busy == TO - 1) begin
        m_phase <= 2; m_err <= 1'b1;
      end else begin
        m_busy <= m_busy + 1;
      end
    end else begin
      m_phase <= 0;
    end
  end

  // Requesters, memory responder and done log.
  int ic_left = 0, dc_left = 0, wr_left = 0;
  bit mem_auto = 1'b1, line_rand = 1'b1;
  int mem_lat = 1, mem_cnt = 0;
  logic [LW-1:0] line_next = '0;
  int dlog[$];

  task automatic step();
    bit exp_rd, exp_wr;
    @(negedge clk);
    exp_rd = (m_phase == 1) && (m_who != 2);
    exp_wr = (m_phase == 1) && (m_who == 2);
    check("mem_read_req", o_mem_read_req, exp_rd);
    check("mem_write_valid", o_mem_write_valid, exp_wr);
    if (exp_rd) check("mem_read_address", o_mem_read_address, m_addr);
    if (exp_wr) begin
      check("mem_write_address", o_mem_write_address, m_addr);
      check("mem_write_data", o_mem_write_data, m_data);
      check("write_strobe", o_write_strobe, m_strb);
    end
    check("ic_rd_done", o_ic_rd_done, (m_phase == 2) && (m_who == 0));
    check("dc_rd_done", o_dc_rd_done, (m_phase == 2) && (m_who == 1));
    check("dc_wr_done", o_dc_wr_done, (m_phase == 2) && (m_who == 2));
    check("line", o_line, m_line);
    check("timeout_err", o_timeout_err, m_err);
    if (o_ic_rd_done) dlog.push_back(0);
    if (o_dc_rd_done) dlog.push_back(1);
    if (o_dc_wr_done) dlog.push_back(2);
    if (o_ic_rd_done) begin ic_left--; ic_req = 1'b0; end else ic_req = (ic_left > 0);
    if (o_dc_rd_done) begin dc_left--; dc_req = 1'b0; end else dc_req = (dc_left > 0);
    if (o_dc_wr_done) begin wr_left--; wr_req = 1'b0; end else wr_req = (wr_left > 0);
    if (mem_auto) begin
      mem_rd_done = 1'b0;
      mem_wr_done = 1'b0;
      if (o_mem_read_req || o_mem_write_valid) begin
        mem_cnt++;
        if (mem_cnt > mem_lat) begin
          mem_rd_done = o_mem_read_req;
          mem_wr_done = o_mem_write_valid;
          mem_cnt = 0;
          if (line_rand) begin
            for (int k = 0; k < 8; k++) cache_line[k*32 +: 32] = $urandom();
          end else begin
            cache_line = line_next;
          end
        end
      end else begin
        mem_cnt = 0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ic_left = 0; dc_left = 0; wr_left = 0;
    ic_req = 1'b0; dc_req = 1'b0; wr_req = 1'b0;
    mem_rd_done = 1'b0; mem_wr_done = 1'b0; mem_cnt = 0;
    step();
    rst = 1'b0;
  endtask

  task automatic drain(int max);
    int n = 0;
    while ((ic_left > 0 || dc_left > 0 || wr_left > 0) && n < max) begin
      step();
      n++;
    end
    check("drain_outstanding", ic_left + dc_left + wr_left, 0);
    step();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [LW-1:0] saved;
    int at, pulses, dcp, wv, dn;

    // Reset state
    step();
    do_reset();
    check("rst_read_req", o_mem_read_req, 0);
    check("rst_write_valid", o_mem_write_valid, 0);
    check("rst_read_addr", o_mem_read_address, 0);
    check("rst_write_data", o_mem_write_data, 0);
    check("rst_line", o_line, 0);
    check("rst_timeout_err", o_timeout_err, 0);

    // Single I-cache refill, memory responds after 3 request cycles
    mem_auto = 1'b1; line_rand = 1'b0; mem_lat = 3;
    line_next = {32{8'hA5}};
    ic_addr = 64'h1000;
    dlog.delete();
    at = -1; pulses = 0; dcp = 0;
    ic_left = 1; ic_req = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (o_ic_rd_done) begin pulses++; if (at < 0) at = i; end
      if (o_dc_rd_done) dcp++;
    end
    check("ic_done_cycle", at, 5);
    check("ic_done_pulses", pulses, 1);
    check("ic_dc_done_quiet", dcp, 0);
    check("ic_line_a5", o_line, {32{8'hA5}});

    // Write and both reads together: write first, then reads from a fresh pointer
    do_reset();
    line_rand = 1'b1; mem_lat = 1;
    ic_addr = 64'h1100; dc_addr = 64'h2200; wr_addr = 64'h3300;
    wr_data = 64'h0123_4567_89AB_CDEF; wr_strb = 8'hF0;
    dlog.delete();
    ic_left = 1; dc_left = 1; wr_left = 1;
    ic_req = 1'b1; dc_req = 1'b1; wr_req = 1'b1;
    drain(60);
    check("order3_size", dlog.size(), 3);
    check("order3_first_wr", dlog[0], 2);
    check("order3_second_ic", dlog[1], 0);
    check("order3_third_dc", dlog[2], 1);

    // Continuous reads from both caches alternate
    mem_lat = 2;
    dlog.delete();
    ic_left = 4; dc_left = 4; ic_req = 1'b1; dc_req = 1'b1;
    drain(200);
    check("rr_size", dlog.size(), 8);
    for (int k = 0; k < 8; k++) check($sformatf("rr_order%0d", k), dlog[k], k % 2);

    // Stray memory responses are ignored; granted fields stay put
    mem_auto = 1'b0;
    step();
    saved = o_line;
    cache_line = {8{32'hDEAD_BEEF}};
    mem_rd_done = 1'b1; mem_wr_done = 1'b1;
    step();
    mem_rd_done = 1'b0; mem_wr_done = 1'b0;
    step();
    check("stray_line_kept", o_line, saved);
    check("stray_no_wr_done", o_dc_wr_done, 0);
    wr_addr = 64'h4000; wr_data = 64'hCAFE_F00D_1234_5678; wr_strb = 8'h0F;
    wr_left = 1; wr_req = 1'b1;
    step();
    mem_rd_done = 1'b1;
    step();
    mem_rd_done = 1'b0;
    check("wrong_done_still_busy", o_mem_write_valid, 1);
    wr_data = 64'h1111_2222_3333_4444; wr_addr = 64'h5000;
    step();
    check("wr_data_held", o_mem_write_data, 64'hCAFE_F00D_1234_5678);
    check("wr_addr_held", o_mem_write_address, 64'h4000);
    mem_wr_done = 1'b1;
    step();
    mem_wr_done = 1'b0;
    check("wr_done_pulse", o_dc_wr_done, 1);
    step();
    step();

    // Reset in the middle of a D-cache refill
    dlog.delete();
    dc_addr = 64'h6000;
    dc_left = 1; dc_req = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("rddc_busy", o_mem_read_req, 1);
    check("rddc_addr", o_mem_read_address, 64'h6000);
    do_reset();
    check("midrst_read_req", o_mem_read_req, 0);
    check("midrst_dc_done", o_dc_rd_done, 0);
    check("midrst_read_addr", o_mem_read_address, 0);
    check("midrst_line", o_line, 0);
    step();
    check("midrst_no_done_logged", dlog.size(), 0);
    mem_auto = 1'b1; mem_lat = 1;
    ic_addr = 64'h7000; dc_addr = 64'h8000;
    ic_left = 1; dc_left = 1; ic_req = 1'b1; dc_req = 1'b1;
    drain(60);
    check("postrst_size", dlog.size(), 2);
    check("postrst_first_ic", dlog[0], 0);

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers a write: watchdog completes it and latches the error
    mem_auto = 1'b0;
    wr_addr = 64'h9000; wr_left = 1; wr_req = 1'b1;
    wv = 0; dn = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (o_mem_write_valid) wv++;
      if (o_dc_wr_done) dn++;
    end
    check("to_busy_cycles", wv, 8);
    check("to_done_pulses", dn, 1);
    check("to_err_set", o_timeout_err, 1);
    for (int i = 0; i < 4; i++) step();
    check("to_err_sticky", o_timeout_err, 1);
    do_reset();
    check("to_err_cleared", o_timeout_err, 0);
`else
    // Without the watchdog a silent memory keeps the write pending
    mem_auto = 1'b0;
    wr_addr = 64'h9000; wr_left = 1; wr_req = 1'b1;
    wv = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (o_mem_write_valid) wv++;
    end
    check("nowd_busy_cycles", wv, 30);
    check("nowd_err_low", o_timeout_err, 0);
    mem_wr_done = 1'b1;
    step();
    mem_wr_done = 1'b0;
    check("nowd_wr_done", o_dc_wr_done, 1);
    step();
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
